// File: rtl/multi_flux_fifo.sv
// multi_flux_fifo: tagged writes steered into FLUX independent FIFOs, read back through a one-hot select.
// Define FIFO_ERR_EN to add sticky err_ovf/err_unf outputs.
module multi_flux_fifo #(
  parameter int FLUX = 2,
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH = 4,
  localparam int TAG_WIDTH = $clog2(FLUX),
  localparam int WIDTH = DATA_WIDTH + TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [WIDTH-1:0] din,
  output logic [FLUX-1:0]  full,
  input  logic [FLUX-1:0]  read,
  output logic [WIDTH-1:0] dout,
  output logic [FLUX-1:0]  empty
`ifdef FIFO_ERR_EN
  ,
  output logic [FLUX-1:0]  err_ovf,
  output logic [FLUX-1:0]  err_unf
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TAG_WIDTH:0] FLUX_T = (TAG_WIDTH+1)'(FLUX);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [FLUX][DEPTH];
  logic [PW-1:0] wptr_q [FLUX];
  logic [PW-1:0] wptr_d [FLUX];
  logic [PW-1:0] rptr_q [FLUX];
  logic [PW-1:0] rptr_d [FLUX];
  logic [CW-1:0] cnt_q [FLUX];
  logic [CW-1:0] cnt_d [FLUX];
  logic [FLUX-1:0] wr_ok, rd_ok, wr_hit;
  logic [TAG_WIDTH-1:0] tag;
  logic tag_ok;
  assign tag = din[WIDTH-1:DATA_WIDTH];
  assign tag_ok = {1'b0, tag} < FLUX_T;
  // Flags come only from registered counts, never from this cycle's write/read.
  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      empty[i] = cnt_q[i] == '0;
      full[i] = cnt_q[i] == DEPTH_C;
    end
  end
  always_comb begin
    dout = '0;
    for (int i = 0; i < FLUX; i++) begin
      wr_hit[i] = write && tag_ok && tag == TAG_WIDTH'(i);
      wr_ok[i] = wr_hit[i] && !full[i];
      rd_ok[i] = $onehot(read) && read[i] && !empty[i];
      wptr_d[i] = wr_ok[i] ? wptr_q[i] + 1'b1 : wptr_q[i];
      rptr_d[i] = rd_ok[i] ? rptr_q[i] + 1'b1 : rptr_q[i];
      cnt_d[i] = (wr_ok[i] && !rd_ok[i]) ? cnt_q[i] + 1'b1 :
                 (rd_ok[i] && !wr_ok[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
      if (rd_ok[i]) dout = {TAG_WIDTH'(i), mem_q[i][rptr_q[i]]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '{default: '0};
      rptr_q <= '{default: '0};
      cnt_q <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < FLUX; i++)
      if (wr_ok[i]) mem_q[i][wptr_q[i]] <= din[DATA_WIDTH-1:0];
  end
`ifdef FIFO_ERR_EN
  logic [FLUX-1:0] ovf_q, ovf_d, unf_q, unf_d;
  // Out-of-range tags are charged to the last flux.
  always_comb begin
    unf_d = unf_q | (read & empty);
    ovf_d = ovf_q | (wr_hit & full);
    if (write && !tag_ok) ovf_d[FLUX-1] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;
`endif
endmodule

// File: tb/tb_multi_flux_fifo.sv
// tb_multi_flux_fifo: randomized and directed checks of multi_flux_fifo against per-flux queue model.
module tb_multi_flux_fifo;
  logic clk = 1'b0;
  logic rst_n;
  logic write;
  logic [18:0] din;
  logic [1:0] full, read, empty;
  logic [18:0] dout;
  logic [17:0] mq [2][$];
  logic [1:0] ovf_m, unf_m;
  int n_cmp = 0;
  int n_err = 0;
`ifdef FIFO_ERR_EN
  logic [1:0] err_ovf, err_unf;
`endif

  multi_flux_fifo dut (
    .clk(clk), .rst_n(rst_n), .write(write), .din(din), .full(full),
    .read(read), .dout(dout), .empty(empty)
`ifdef FIFO_ERR_EN
    , .err_ovf(err_ovf), .err_unf(err_unf)
`endif
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic w, input logic [18:0] d, input logic [1:0] r, input string name);
    logic [18:0] exp;
    logic [1:0] ee, ef;
    int sz[2];
    int t;
    write = w; din = d; read = r;
    #1;
    exp = '0;
    for (int k = 0; k < 2; k++) begin
      sz[k] = mq[k].size();
      ee[k] = sz[k] == 0;
      ef[k] = sz[k] == 4;
      if (r == 2'(1 << k) && sz[k] > 0) exp = {1'(k), mq[k][0]};
    end
    n_cmp++;
    if (dout !== exp) begin n_err++; $display("FAIL %s dout: got %h expected %h", name, dout, exp); end
    n_cmp++;
    if (empty !== ee) begin n_err++; $display("FAIL %s empty: got %b expected %b", name, empty, ee); end
    n_cmp++;
    if (full !== ef) begin n_err++; $display("FAIL %s full: got %b expected %b", name, full, ef); end
`ifdef FIFO_ERR_EN
    n_cmp++;
    if (err_ovf !== ovf_m || err_unf !== unf_m) begin
      n_err++; $display("FAIL %s err: got %b/%b expected %b/%b", name, err_ovf, err_unf, ovf_m, unf_m);
    end
`endif
    @(posedge clk);
    #1;
    t = int'(d[18]);
    for (int k = 0; k < 2; k++) begin
      if (r == 2'(1 << k) && sz[k] > 0) void'(mq[k].pop_front());
      if (r[k] && sz[k] == 0) unf_m[k] = 1'b1;
    end
    if (w && sz[t] < 4) mq[t].push_back(d[17:0]);
    if (w && sz[t] == 4) ovf_m[t] = 1'b1;
  endtask

  task automatic do_reset();
    write = 1'b0; read = 2'b00;
    rst_n = 1'b0;
    mq[0].delete(); mq[1].delete();
    ovf_m = '0; unf_m = '0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 2; k++)
      while (mq[k].size() > 0) cycle(1'b0, '0, 2'(1 << k), "drain");
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, {1'b0, 18'(100 + i)}, 2'b00, "rst_fill");
    write = 1'b0; read = 2'b01;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (empty !== 2'b11) begin n_err++; $display("FAIL rst_empty: got %b expected 11", empty); end
    n_cmp++;
    if (full !== 2'b00) begin n_err++; $display("FAIL rst_full: got %b expected 00", full); end
    n_cmp++;
    if (dout !== 19'd0) begin n_err++; $display("FAIL rst_dout: got %h expected 0", dout); end
    mq[0].delete(); mq[1].delete();
    ovf_m = '0; unf_m = '0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, '0, 2'b01, "rst_read_after");
    ovf_m = '0; unf_m = '0;
    do_reset();
  endtask

  task automatic test_order();
    for (int v = 5; v <= 8; v++) cycle(1'b1, {1'b1, 18'(v)}, 2'b00, "order_wr");
    n_cmp++;
    if (full !== 2'b10) begin n_err++; $display("FAIL order_full: got %b expected 10", full); end
    for (int v = 5; v <= 8; v++) begin
      n_cmp++;
      read = 2'b10; #1;
      if (dout !== {1'b1, 18'(v)}) begin n_err++; $display("FAIL order_head: got %h expected %h", dout, {1'b1, 18'(v)}); end
      cycle(1'b0, '0, 2'b10, "order_rd");
    end
    n_cmp++;
    if (empty[1] !== 1'b1) begin n_err++; $display("FAIL order_empty: got %b expected 1", empty[1]); end
  endtask

  task automatic test_overflow();
    for (int v = 5; v <= 8; v++) cycle(1'b1, {1'b1, 18'(v)}, 2'b00, "ovf_wr");
    cycle(1'b1, {1'b1, 18'd9}, 2'b00, "ovf_drop");
    cycle(1'b1, {1'b1, 18'd10}, 2'b10, "ovf_full_rw");
    drain();
    cycle(1'b0, '0, 2'b10, "ovf_rd_empty");
`ifdef FIFO_ERR_EN
    n_cmp++;
    if (err_ovf[1] !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", err_ovf[1]); end
`endif
    do_reset();
  endtask

  task automatic test_simul();
    cycle(1'b1, {1'b0, 18'd1}, 2'b00, "sim_wr");
    cycle(1'b1, {1'b0, 18'd2}, 2'b00, "sim_wr");
    cycle(1'b1, {1'b0, 18'h3FFFF}, 2'b01, "sim_rw");
    n_cmp++;
    if (mq[0].size() != 2 || mq[0][1] !== 18'h3FFFF) begin n_err++; $display("FAIL sim_model: got %0d expected 2", mq[0].size()); end
    cycle(1'b1, {1'b0, 18'd3}, 2'b01, "sim_empty_rw");
    drain();
    cycle(1'b1, {1'b0, 18'd4}, 2'b01, "sim_empty_rw2");
    drain();
  endtask

  task automatic test_indep();
    cycle(1'b1, {1'b0, 18'd10}, 2'b00, "ind_wr");
    cycle(1'b1, {1'b1, 18'd20}, 2'b00, "ind_wr");
    cycle(1'b1, {1'b0, 18'd11}, 2'b00, "ind_wr");
    cycle(1'b0, '0, 2'b10, "ind_rd1");
    cycle(1'b1, {1'b1, 18'd21}, 2'b01, "ind_cross");
    drain();
  endtask

  task automatic test_illegal();
    cycle(1'b1, {1'b0, 18'd30}, 2'b00, "ill_wr");
    cycle(1'b1, {1'b1, 18'd31}, 2'b00, "ill_wr");
    cycle(1'b0, '0, 2'b11, "ill_both");
    cycle(1'b0, '0, 2'b11, "ill_both2");
    drain();
    cycle(1'b0, '0, 2'b01, "ill_empty0");
    cycle(1'b0, '0, 2'b10, "ill_empty1");
`ifdef FIFO_ERR_EN
    n_cmp++;
    if (err_unf !== 2'b11) begin n_err++; $display("FAIL unf_flag: got %b expected 11", err_unf); end
`endif
    do_reset();
  endtask

  task automatic test_random();
    logic [1:0] r;
    for (int i = 0; i < 400; i++) begin
      r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) r = 2'b11;
      else if (r == 2'b11) r = 2'b00;
      cycle(1'($urandom_range(0, 1)), {1'($urandom_range(0, 1)), 18'($urandom)}, r, "random");
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0; write = 1'b0; din = '0; read = '0;
    ovf_m = '0; unf_m = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_order();
    test_overflow();
    test_simul();
    test_indep();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
